// File: rtl/uart_pkg.sv
// Shared UART definitions: register word offsets, STATUS bit positions, RX FSM states.
package uart_pkg;
    localparam int unsigned REG_RXDATA   = 0;
    localparam int unsigned REG_STATUS   = 1;

    localparam int unsigned STAT_NE      = 0;
    localparam int unsigned STAT_OVR     = 1;
    localparam int unsigned STAT_FERR    = 2;
    localparam int unsigned STAT_CNT_LSB = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fall-through head; push on full is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_slave.sv
// 8N1 UART receiver with an RX FIFO drained over the shared soc bus (RXDATA/STATUS).
module uart_rx_slave
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] BUS_addr,
    inout  wire  [31:0] BUS_data,
    input  logic        BUS_req,
    inout  wire         BUS_ready,
    input  logic        BUS_RW,
    input  logic        RxD,
    output logic        rx_int
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    rx_state_e     r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_rx_meta, r_rxs;
    logic          w_push, w_ferr_set;

    logic          r_ovr, r_ferr, r_armed, r_ready, r_rd;
    logic [31:0]   r_rdata;
    logic          w_hit_rx, w_hit_st, w_acc, w_pop, w_full, w_empty;
    logic [7:0]    w_head;
    logic [AW:0]   w_count;
    logic [31:0]   w_rdval, w_status;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
        end else begin
            r_rx_meta <= RxD;
            r_rxs     <= r_rx_meta;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_ferr_set  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (!r_rxs) w_state_nxt = START;
            end
            START: if (r_cnt == HALF_M1) begin
                w_cnt_nxt = '0;
                w_bit_nxt = '0;
                w_state_nxt = r_rxs ? IDLE : DATA;
            end
            DATA: if (r_cnt == FULL_M1) begin
                w_cnt_nxt   = '0;
                w_shift_nxt = {r_rxs, r_shift[7:1]};
                w_bit_nxt   = r_bit + 1'b1;
                if (r_bit == 3'd7) w_state_nxt = STOP;
            end
            STOP: if (r_cnt == FULL_M1) begin
                w_cnt_nxt = '0;
                if (r_rxs) begin
                    w_push      = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_ferr_set  = 1'b1;
                    w_state_nxt = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                w_cnt_nxt = '0;
                if (r_rxs) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .clr     (clr),
        .i_push  (w_push),
        .i_din   (r_shift),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_hit_rx = (BUS_addr == BASE_ADDR + 32'(REG_RXDATA));
    assign w_hit_st = (BUS_addr == BASE_ADDR + 32'(REG_STATUS));
    assign w_acc    = BUS_req && r_armed && (w_hit_rx || w_hit_st);
    assign w_pop    = w_acc && !BUS_RW && w_hit_rx;

    always_comb begin
        w_status = '0;
        w_status[STAT_NE]   = !w_empty;
        w_status[STAT_OVR]  = r_ovr;
        w_status[STAT_FERR] = r_ferr;
        w_status[STAT_CNT_LSB +: 4] = 4'(w_count);
    end

    assign w_rdval = w_hit_rx ? (w_empty ? 32'd0 : {23'd0, 1'b1, w_head}) : w_status;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
            r_armed <= 1'b1;
            r_ready <= 1'b0;
            r_rd    <= 1'b0;
            r_rdata <= '0;
        end else begin
            // A set in the same cycle as a write-1-to-clear must win.
            if (w_push && w_full && !w_pop)
                r_ovr <= 1'b1;
            else if (w_acc && BUS_RW && w_hit_st && BUS_data[STAT_OVR])
                r_ovr <= 1'b0;
            if (w_ferr_set)
                r_ferr <= 1'b1;
            else if (w_acc && BUS_RW && w_hit_st && BUS_data[STAT_FERR])
                r_ferr <= 1'b0;
            if (w_acc)
                r_armed <= 1'b0;
            else if (!BUS_req)
                r_armed <= 1'b1;
            r_ready <= w_acc;
            r_rd    <= w_acc && !BUS_RW;
            if (w_acc)
                r_rdata <= w_rdval;
        end
    end

    assign BUS_ready = r_ready ? 1'b1 : 1'bz;
    assign BUS_data  = (r_ready && r_rd) ? r_rdata : 32'bz;
    assign rx_int    = (w_count != '0);
endmodule

// File: tb/tb_uart_rx_slave.sv
// Directed bench for uart_rx_slave: serial frames in, bus reads/writes out, immediate-assert checks.
module tb_uart_rx_slave;
    localparam int          CPB  = 16;
    localparam logic [31:0] BASE = 32'h0000_2000;
    localparam logic [31:0] A_RX = BASE;
    localparam logic [31:0] A_ST = BASE + 32'd1;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] BUS_addr = '0;
    logic        BUS_req = 1'b0;
    logic        BUS_RW = 1'b0;
    logic        RxD = 1'b1;
    logic        rx_int;
    wire  [31:0] BUS_data;
    wire         BUS_ready;
    logic        tb_drv = 1'b0;
    logic [31:0] tb_wdata = '0;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;
    int pulses;

    assign BUS_data = tb_drv ? tb_wdata : 32'bz;

    always #5 clk = ~clk;

    uart_rx_slave #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .clr       (clr),
        .BUS_addr  (BUS_addr),
        .BUS_data  (BUS_data),
        .BUS_req   (BUS_req),
        .BUS_ready (BUS_ready),
        .BUS_RW    (BUS_RW),
        .RxD       (RxD),
        .rx_int    (rx_int)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bitwait();
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Start bit, nbits data bits LSB first; full frames add the given stop bit and return to idle.
    task automatic send_frame(input logic [7:0] d, input logic stopb, input int nbits);
        @(posedge clk); #1;
        RxD = 1'b0;
        bitwait();
        for (int i = 0; i < nbits; i++) begin
            RxD = d[i];
            bitwait();
        end
        if (nbits == 8) begin
            RxD = stopb;
            bitwait();
            RxD = 1'b1;
            repeat (4) @(posedge clk);
        end
    endtask

    // Each request is held for 4+hold sampling cycles; every ready pulse seen is counted.
    task automatic bus_xact(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                            input int hold, output logic [31:0] rdv, output int np);
        @(posedge clk); #1;
        BUS_req = 1'b1; BUS_addr = addr; BUS_RW = rw;
        tb_drv = rw; tb_wdata = wd;
        np = 0; rdv = '0;
        for (int k = 0; k < 4 + hold; k++) begin
            @(negedge clk);
            if (BUS_ready === 1'b1) begin
                np++;
                if (!rw) rdv = BUS_data;
            end
        end
        @(posedge clk); #1;
        BUS_req = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus_xact(1'b0, addr, 32'd0, 0, rd, pulses);
        check({tag, "_ready"}, 32'(pulses), 32'd1);
        check(tag, rd, exp);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] wd);
        bus_xact(1'b1, addr, wd, 0, rd, pulses);
        check("write_ready", 32'(pulses), 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check("rst_int", {31'd0, rx_int}, 32'd0);
        check("rst_ready", {31'd0, BUS_ready === 1'b1}, 32'd0);
        bus_read("rst_status", A_ST, 32'h0);

        // single byte
        send_frame(8'hA5, 1'b1, 8);
        @(negedge clk);
        check("a5_int_hi", {31'd0, rx_int}, 32'd1);
        bus_read("a5_status", A_ST, 32'h11);
        bus_read("a5_data", A_RX, 32'h0000_01A5);
        @(negedge clk);
        check("a5_int_lo", {31'd0, rx_int}, 32'd0);

        // glitch shorter than half a bit, then empty reads
        @(posedge clk); #1 RxD = 1'b0;
        repeat (3) @(posedge clk);
        #1 RxD = 1'b1;
        repeat (40) @(posedge clk);
        bus_read("glitch_status", A_ST, 32'h0);
        bus_read("empty_rx", A_RX, 32'h0);
        bus_read("empty_status", A_ST, 32'h0);

        // framing error, W1C, recovery
        send_frame(8'h3C, 1'b0, 8);
        repeat (4) @(posedge clk);
        bus_read("ferr_status", A_ST, 32'h4);
        bus_write(A_ST, 32'h4);
        bus_read("ferr_cleared", A_ST, 32'h0);
        send_frame(8'h11, 1'b1, 8);
        bus_read("after_ferr", A_RX, 32'h0000_0111);

        // overrun
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 8);
        bus_read("ovr_status", A_ST, 32'h83);
        for (int i = 1; i <= 8; i++) bus_read("ovr_drain", A_RX, 32'h100 | 32'(i));
        bus_read("ovr_empty", A_RX, 32'h0);
        bus_read("ovr_sticky", A_ST, 32'h2);
        bus_write(A_ST, 32'h2);
        bus_read("ovr_cleared", A_ST, 32'h0);

        // full FIFO: pop accepted on the very edge that pushes the 9th byte
        for (int i = 0; i < 8; i++) send_frame(8'h21 + 8'(i), 1'b1, 8);
        bus_read("full_status", A_ST, 32'h81);
        fork
            send_frame(8'h29, 1'b1, 8);
            begin
                @(posedge clk);
                repeat (153) @(posedge clk);
                bus_xact(1'b0, A_RX, 32'd0, 0, rd, pulses);
            end
        join
        check("pp_data", rd, 32'h0000_0121);
        bus_read("pp_status", A_ST, 32'h81);
        for (int i = 2; i <= 9; i++) bus_read("pp_drain", A_RX, 32'h100 | 32'(8'h20 + 8'(i)));

        // reset mid-frame with a byte already queued
        send_frame(8'h77, 1'b1, 8);
        send_frame(8'h5A, 1'b1, 4);
        repeat (8) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        RxD = 1'b1;
        @(negedge clk);
        check("midrst_int", {31'd0, rx_int}, 32'd0);
        check("midrst_ready", {31'd0, BUS_ready === 1'b1}, 32'd0);
        repeat (4 * CPB) @(posedge clk);
        bus_read("midrst_status", A_ST, 32'h0);
        send_frame(8'h5A, 1'b1, 8);
        bus_xact(1'b0, A_RX, 32'd0, 6, rd, pulses);
        check("held_req_pulses", 32'(pulses), 32'd1);
        check("held_req_data", rd, 32'h0000_015A);
        bus_read("final_status", A_ST, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_slave.md
Name: uart_rx_slave

Overview:
- Bus-slave UART receiver. It is the receive-side counterpart of uart_tx and sits on the same shared soc bus: BUS_addr, BUS_data, BUS_req, BUS_ready, BUS_RW.
- Deserialises 8N1 frames from the RxD pin into an 8-entry FIFO. The CPU drains the FIFO through two memory-mapped word registers.
- Raises a level interrupt while data is pending.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit (>=4)
BASE_ADDR, 32'h0000_2000, word address of RXDATA; STATUS is BASE_ADDR+1
FIFO_DEPTH, 8, receive FIFO entries (power of 2)

Ports:
clk  input  1  system clock (single clock domain)
clr  input  1  synchronous, active-high reset
BUS_addr  input  32  word address (byte address >>2, as wired in soc)
BUS_data  inout  32  driven only during own read-ready cycle, else high-Z
BUS_req  input  1  master request
BUS_ready  inout  1  driven 1 for own ready cycle, else high-Z
BUS_RW  input  1  1=write, 0=read
RxD  input  1  asynchronous serial line, idle high
rx_int  output  1  high while FIFO not empty

Behaviour:
- Reset (clr=1 at posedge clk):
  - FIFO emptied; overrun/frame flags cleared; RX FSM to IDLE.
  - rx_int=0; BUS_data and BUS_ready released (Z).
  - Synchroniser flops set to 1.
- Reset mid-frame abandons the frame. The receiver then waits for a new falling edge on the line.
- RxD passes through a 2-flop synchroniser (rxs). All decisions use rxs.
- RX FSM:
  - IDLE: on rxs=0, go to START and set cnt=0.
  - START: when cnt=CLKS_PER_BIT/2-1, sample.
    - If rxs=1, treat as a glitch and return to IDLE.
    - Otherwise go to DATA with bit index 0 and reset cnt.
  - DATA: sample at cnt=CLKS_PER_BIT-1 (mid-bit). Shift in LSB first. After bit 7, go to STOP.
  - STOP: sample at mid-bit.
    - If rxs=1, push the byte and go to IDLE.
    - If rxs=0, set frame_err, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then go to IDLE.
- Byte-to-FIFO latency is one clk after the stop-bit sample.
- Push when FIFO full: byte dropped, overrun set, FIFO contents unchanged.
- Bus register map:
  - RXDATA (read): bit8=valid, bits[7:0]=head byte, other bits 0. Reading with the FIFO non-empty pops the head. Reading empty returns 0 and does not pop.
  - RXDATA (write): ignored, but still acknowledged.
  - STATUS (read): bit0=not_empty, bit1=overrun, bit2=frame_err, bits[7:4]=count (0..FIFO_DEPTH), rest 0.
  - STATUS (write): write-1-to-clear for bits 1 and 2; other bits ignored.
- Bus handshake:
  - A transaction is accepted when BUS_req=1 and BUS_addr hits, with the slave armed.
  - Next cycle: BUS_ready driven 1 for exactly one cycle. On reads, BUS_data carries the value captured at acceptance during that cycle.
  - The pop/clear takes effect at acceptance.
  - The slave disarms after accepting and rearms only after seeing BUS_req=0, so one request yields one response.
  - Outside the ready cycle, BUS_ready and BUS_data are high-Z.
- Simultaneous push and pop in one cycle: both performed, count unchanged. A full FIFO plus pop plus push is accepted with no overrun.
- Simultaneous error-set and W1C in one cycle: set wins.
- Pointers wrap modulo FIFO_DEPTH. count is kept as log2(FIFO_DEPTH)+1 bits.
- rx_int is combinational from count!=0 and tracks count with no added latency.

Decomposition:
- Shared package uart_pkg: register offsets (RXDATA=0, STATUS=1), STATUS bit positions, RX FSM state enum (IDLE, START, DATA, STOP, WAIT_HIGH). uart_tx should adopt the same offsets.
- One natural sub-module: sync_fifo (width 8, depth FIFO_DEPTH, push/pop/full/empty/count). It is reusable for a future TX FIFO.
- The bus decode, synchroniser and FSM stay in uart_rx_slave.

Test Plan:
- Byte send: drive 0xA5 on RxD at CLKS_PER_BIT=16, then read RXDATA. Expect BUS_ready for 1 cycle, data 32'h0000_01A5, rx_int rising then falling after the read.
- Glitch and empty read: RxD low for 3 clks, then high. Expect no byte and STATUS=0. An empty RXDATA read returns 0 and STATUS is still count=0.
- Framing error: send 0x3C with stop bit 0. Expect STATUS bit2=1 and count=0. Write 32'h4 to STATUS, then STATUS reads 0. Next valid byte 0x11 is received normally.
- Overrun: send 9 bytes 0x01..0x09 without reading. Expect count=8 and overrun=1; eight reads return 0x101..0x108, then an empty read.
- Simultaneous push/pop with the FIFO full: pop exactly on the stop-sample push cycle. Expect count stays 8 and overrun stays 0.
- Reset mid-frame: assert clr during DATA bit 4. Expect all outputs back at reset values, the next frame 0x5A received correctly, and BUS_req held high yielding only one ready pulse.
